// File: rtl/memory_pipe.sv
// Byte-addressed word RAM with valid/ready request/response channels, programmable read latency
// and an in-order response queue. Optional address checking: define MEMORY_PIPE_ERR_EN.
module memory_pipe #(
   parameter int SIZE       = 4096,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [31:0]             req_addr_i,
   input  logic                    req_we_i,
   input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int WORDS = SIZE / NB;
   localparam int AW    = $clog2(SIZE);
   localparam int OW    = $clog2(NB);
   localparam int IW    = AW - OW;
   localparam int QD    = LATENCY + 1;
   localparam int PW    = $clog2(QD);
   localparam int CW    = $clog2(QD + 1);

   if (SIZE % NB != 0) begin : g_bad_size
      $fatal(1, "memory_pipe: SIZE must be a multiple of DATA_WIDTH/8");
   end
   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $fatal(1, "memory_pipe: DATA_WIDTH must be 32 or 64");
   end
   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $fatal(1, "memory_pipe: LATENCY must be in 1..4");
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
   endfunction

   logic [DATA_WIDTH-1:0] mem_array [WORDS];
   logic [IW-1:0]         idx_s;
   logic                  in_range_s;
   logic                  addr_err_s;
   logic                  acc_s;
   logic                  pop_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] ent_data_s;
   logic                  pipe_valid_s;
   logic [DATA_WIDTH-1:0] pipe_data_s;
   logic                  pipe_err_s;

   assign idx_s      = req_addr_i[AW-1:OW];
   assign in_range_s = (int'(idx_s) < WORDS);

`ifdef MEMORY_PIPE_ERR_EN
   assign addr_err_s = (req_addr_i >= 32'(SIZE)) || (req_addr_i[OW-1:0] != '0) || !in_range_s;
`else
   // Upper and byte-offset address bits are intentionally ignored: the address wraps.
   logic unused_addr_s;
   assign unused_addr_s = ^{req_addr_i[31:AW], req_addr_i[OW-1:0]};
   assign addr_err_s    = 1'b0;
`endif

   assign acc_s      = req_valid_i & req_ready_o & ~rst;
   assign rd_word_s  = in_range_s ? mem_array[idx_s] : '0;
   assign ent_data_s = (req_we_i | addr_err_s) ? '0 : rd_word_s;

   // Byte lanes commit on the accept edge; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (acc_s && req_we_i && !addr_err_s && in_range_s) begin
         for (int b = 0; b < NB; b++) begin
            if (req_wmask_i[b]) begin
               mem_array[idx_s][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
         end
      end
   end

   if (LATENCY == 1) begin : g_nopipe
      assign pipe_valid_s = acc_s;
      assign pipe_data_s  = ent_data_s;
      assign pipe_err_s   = addr_err_s;
   end else begin : g_pipe
      logic [LATENCY-2:0]    v_q, v_d, e_q, e_d;
      logic [DATA_WIDTH-1:0] d_q [LATENCY-1];
      logic [DATA_WIDTH-1:0] d_d [LATENCY-1];

      always_comb begin
         v_d[0] = acc_s;
         e_d[0] = addr_err_s;
         d_d[0] = ent_data_s;
         for (int i = 1; i < LATENCY - 1; i++) begin
            v_d[i] = v_q[i-1];
            e_d[i] = e_q[i-1];
            d_d[i] = d_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= '0;
         end else begin
            v_q <= v_d;
         end
         e_q <= e_d;
         d_q <= d_d;
      end

      assign pipe_valid_s = v_q[LATENCY-2];
      assign pipe_data_s  = d_q[LATENCY-2];
      assign pipe_err_s   = e_q[LATENCY-2];
   end

   logic [DATA_WIDTH-1:0] q_data_q [QD];
   logic [DATA_WIDTH-1:0] q_data_d [QD];
   logic [QD-1:0]         q_err_q, q_err_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         q_cnt_q, q_cnt_d, cnt_q, cnt_d;

   assign rsp_valid_o = (q_cnt_q != '0);
   assign rsp_rdata_o = rsp_valid_o ? q_data_q[rd_ptr_q] : '0;
   assign rsp_err_o   = rsp_valid_o & q_err_q[rd_ptr_q];
   assign req_ready_o = (cnt_q != CW'(QD));
   assign pop_s       = rsp_valid_o & rsp_ready_i;

   // The pipeline never stalls; the credit limit guarantees the queue has room for it.
   always_comb begin
      q_data_d = q_data_q;
      q_err_d  = q_err_q;
      if (pipe_valid_s) begin
         q_data_d[wr_ptr_q] = pipe_data_s;
         q_err_d[wr_ptr_q]  = pipe_err_s;
         wr_ptr_d           = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({pipe_valid_s, pop_s})
         2'b10:   q_cnt_d = q_cnt_q + CW'(1);
         2'b01:   q_cnt_d = q_cnt_q - CW'(1);
         default: q_cnt_d = q_cnt_q;
      endcase
      case ({acc_s, pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         q_cnt_q  <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         q_cnt_q  <= q_cnt_d;
         cnt_q    <= cnt_d;
      end
      q_data_q <= q_data_d;
      q_err_q  <= q_err_d;
   end
endmodule

// File: tb/tb_memory_pipe.sv
// Directed, table-driven bench for memory_pipe (LATENCY=2) plus sequences for backpressure,
// throughput and mid-operation reset.
module tb_memory_pipe;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready_o, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        rsp_valid_o, rsp_ready, rsp_err_o;
   logic [31:0] rsp_rdata_o;

   int checks = 0;
   int errors = 0;

   memory_pipe #(.SIZE(4096), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.mask = mask; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      vecs.push_back(v);
   endtask

   // One isolated request; returns the response and the accept-to-valid latency.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      @(negedge clk);
      check("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wmask = mask; req_wdata = wdata;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata_o;
      err   = rsp_err_o;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          acc;
      int          got;
      int          seen;
      logic [31:0] bp_addr [4];
      logic [31:0] bp_exp  [4];

      bp_addr = '{32'h10, 32'h20, 32'h24, 32'hFFC};
      bp_exp  = '{32'hDEADBEEF, 32'h11BB33DD, 32'h01020304, 32'h89ABCDEF};

      add(1'b1, 32'h000, 4'hF, 32'h00000001, 32'h0, 1'b0);
      add(1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
      add(1'b0, 32'h010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);
      add(1'b1, 32'h020, 4'hF, 32'h11223344, 32'h0, 1'b0);
      add(1'b1, 32'h020, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0);
      add(1'b0, 32'h020, 4'hF, 32'h0,        32'h11BB33DD, 1'b0);
      add(1'b1, 32'h024, 4'hF, 32'h01020304, 32'h0, 1'b0);
      add(1'b1, 32'h024, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
      add(1'b0, 32'h024, 4'h0, 32'h0,        32'h01020304, 1'b0);
      add(1'b1, 32'hFFC, 4'hF, 32'h89ABCDEF, 32'h0, 1'b0);
      add(1'b0, 32'hFFC, 4'h0, 32'h0,        32'h89ABCDEF, 1'b0);
`ifdef MEMORY_PIPE_ERR_EN
      add(1'b0, 32'h013, 4'h0, 32'h0,        32'h0, 1'b1);
      add(1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b1);
      add(1'b0, 32'h000, 4'h0, 32'h0,        32'h00000001, 1'b0);
      add(1'b0, 32'h4012, 4'h0, 32'h0,       32'h0, 1'b1);
`else
      add(1'b0, 32'h013, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);
      add(1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0);
      add(1'b0, 32'h000, 4'h0, 32'h0,        32'h5A5A5A5A, 1'b0);
      add(1'b0, 32'h4012, 4'h0, 32'h0,       32'hDEADBEEF, 1'b0);
`endif

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0;
      req_wdata = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
      check("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata_o, 32'd0);
      check("reset_rsp_err",   {31'b0, rsp_err_o}, 32'd0);

      foreach (vecs[i]) begin
         do_req(vecs[i].we, vecs[i].addr, vecs[i].mask, vecs[i].wdata, rd, er, lat);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      end

      // Backpressure: only LAT+1 reads may be accepted while responses are blocked.
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b0; req_addr = bp_addr[acc % 4];
         if (req_ready_o) acc++;
      end
      @(negedge clk);
      check("bp_accepted", 32'(acc), 32'(LAT + 1));
      check("bp_req_ready", {31'b0, req_ready_o}, 32'd0);
      check("bp_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      check("bp_head_rdata", rsp_rdata_o, bp_exp[0]);
      repeat (3) @(negedge clk);
      check("bp_head_stable", rsp_rdata_o, bp_exp[0]);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid_o) begin
            if (got <= LAT) check($sformatf("bp_rsp%0d", got), rsp_rdata_o, bp_exp[got]);
            got++;
         end
         @(negedge clk);
      end
      check("bp_rsp_count", 32'(got), 32'(LAT + 1));

      // Throughput: 16 back-to-back reads, responses on consecutive cycles.
      got = 0;
      for (int c = 0; c < 16 + LAT + 4; c++) begin
         @(negedge clk);
         if (rsp_valid_o) begin
            check($sformatf("tp_rsp%0d_data", got), rsp_rdata_o, bp_exp[got % 4]);
            check($sformatf("tp_rsp%0d_cycle", got), 32'(c), 32'(got + LAT));
            got++;
         end
         if (c < 16) begin
            check($sformatf("tp_ready%0d", c), {31'b0, req_ready_o}, 32'd1);
            req_valid = 1'b1; req_we = 1'b0; req_addr = bp_addr[c % 4];
         end else begin
            req_valid = 1'b0;
         end
      end
      check("tp_rsp_count", 32'(got), 32'd16);

      // Reset with two reads in flight: they are dropped, earlier writes survive.
      do_req(1'b1, 32'h30, 4'hF, 32'h12345678, rd, er, lat);
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
      @(negedge clk);
      req_addr = 32'h20;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid_rsp_pending", {31'b0, rsp_valid_o}, 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("mid_req_ready", {31'b0, req_ready_o}, 32'd1);
      check("mid_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      check("mid_rsp_rdata", rsp_rdata_o, 32'd0);
      rsp_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid_o) seen++;
      end
      check("mid_no_stale_rsp", 32'(seen), 32'd0);
      do_req(1'b0, 32'h30, 4'h0, 32'h0, rd, er, lat);
      check("mid_write_kept", rd, 32'h12345678);
      do_req(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
      check("mid_old_data", rd, 32'hDEADBEEF);
      check("mid_latency", 32'(lat), 32'(LAT));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
